// File: rtl/speaker_ctrl_i2s.sv
// I2S serialiser for the CS4344 Pmod DAC: divides clk into MCLK/SCK/LRCK and shifts
// out one stereo pair of DATA_W-bit two's-complement samples per frame.
module speaker_ctrl_i2s #(
    parameter int DATA_W    = 16,
    parameter int MCLK_LOG2 = 2,
    parameter int SCK_LOG2  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] audio_left,
    input  logic [DATA_W-1:0] audio_right,
    input  logic              mute,
    output logic              audio_mclk,
    output logic              audio_lrck,
    output logic              audio_sck,
    output logic              audio_sdin,
    output logic              sample_tick
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int CNT_W   = SCK_LOG2 + $clog2(FRAME_W);

    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] shreg;
    logic               sdin_q;
    logic               frame_end;
    logic               slot_end;

    assign frame_end = &cnt;
    assign slot_end  = &cnt[SCK_LOG2-1:0];

    // Clock outputs are straight register bits, so they are glitch-free.
    assign audio_mclk  = cnt[MCLK_LOG2-1];
    assign audio_sck   = cnt[SCK_LOG2-1];
    assign audio_lrck  = cnt[CNT_W-1];
    assign audio_sdin  = sdin_q;
    assign sample_tick = frame_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One shift per slot boundary from slot 1 onward (31 shifts per frame) parks the
    // right-word LSB in the MSB by frame end, so slot 0 of the next frame emits it
    // without a separate hold register. Samples are captured only on the frame-end edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg  <= '0;
            sdin_q <= 1'b0;
        end else if (slot_end) begin
            sdin_q <= shreg[FRAME_W-1];
            if (frame_end) begin
                shreg <= mute ? '0 : {audio_left, audio_right};
            end else begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_speaker_ctrl_i2s.sv
// Self-checking bench for speaker_ctrl_i2s: table of stereo vectors fed to a bit-level
// scoreboard, plus hand sequences for clock timing, async reset and sample_tick rate.
module tb_speaker_ctrl_i2s;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] audio_left = '0;
    logic [15:0] audio_right = '0;
    logic        mute = 1'b0;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick;

    speaker_ctrl_i2s dut (
        .clk         (clk),
        .reset       (reset),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .mute        (mute),
        .audio_mclk  (audio_mclk),
        .audio_lrck  (audio_lrck),
        .audio_sck   (audio_sck),
        .audio_sdin  (audio_sdin),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        m;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t   tbl [8];
    vec_t   expq[$];
    logic   bitq[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     tick_seen = 0;
    bit     rel_pending = 1'b1;
    logic   prev_r0 = 1'b0;
    logic [8:0] tb_cnt;

    // Reference frame counter, reset asynchronously like the design's timebase.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 9'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        vec_t v;
        logic b;
        if (!reset) begin
            check("outputs in reset", {27'b0, audio_mclk, audio_sck, audio_lrck, sample_tick, audio_sdin}, 32'h0);
            bitq.delete();
            expq.delete();
            rel_pending = 1'b1;
        end else begin
            if (rel_pending) begin
                for (int i = 0; i < 32; i++) bitq.push_back(1'b0);
                prev_r0 = 1'b0;
                rel_pending = 1'b0;
            end
            check("clock bits", {28'b0, audio_mclk, audio_sck, audio_lrck, sample_tick},
                  {28'b0, tb_cnt[1], tb_cnt[3], tb_cnt[8], (tb_cnt == 9'd511)});
            if (sample_tick) tick_seen++;
            if (tb_cnt[3:0] == 4'd8 && bitq.size() > 0) begin
                b = bitq.pop_front();
                check("sdin slot", {31'b0, audio_sdin}, {31'b0, b});
            end
            if (tb_cnt == 9'd511 && expq.size() > 0) begin
                v = expq.pop_front();
                bitq.push_back(prev_r0);
                for (int j = 15; j >= 0; j--) bitq.push_back(v.el[j]);
                for (int j = 15; j >= 1; j--) bitq.push_back(v.er[j]);
                prev_r0 = v.er[0];
            end
        end
    end

    task automatic wait_cnt(input logic [8:0] target);
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (tb_cnt == target) return;
        end
        check("wait_cnt timeout", 32'd1, 32'd0);
    endtask

    task automatic lrck_rise_check();
        int found = 0;
        for (int e = 1; e <= 600; e++) begin
            @(posedge clk); #1;
            if (audio_lrck) begin
                found = e;
                break;
            end
        end
        check("lrck first rise edge", found, 256);
    endtask

    // Drive a row mid-frame, then scribble random data just after the frame end
    // while that row is in flight; only the frame-end values may appear on SDIN.
    task automatic apply_row(input int idx);
        wait_cnt(9'd300);
        audio_left  = tbl[idx].l;
        audio_right = tbl[idx].r;
        mute        = tbl[idx].m;
        expq.push_back(tbl[idx]);
        wait_cnt(9'd20);
        audio_left  = 16'($urandom);
        audio_right = 16'($urandom);
        mute        = 1'($urandom);
    endtask

    initial begin
        int t0;
        tbl[0] = '{l:16'hA5C3, r:16'h3C5A, m:1'b0, el:16'hA5C3, er:16'h3C5A};
        tbl[1] = '{l:16'h8000, r:16'h0001, m:1'b0, el:16'h8000, er:16'h0001};
        tbl[2] = '{l:16'h7FFF, r:16'hFFFE, m:1'b0, el:16'h7FFF, er:16'hFFFE};
        tbl[3] = '{l:16'hFFFF, r:16'hFFFF, m:1'b0, el:16'hFFFF, er:16'hFFFF};
        tbl[4] = '{l:16'hFFFF, r:16'hFFFF, m:1'b1, el:16'h0000, er:16'h0000};
        tbl[5] = '{l:16'h1234, r:16'h5678, m:1'b1, el:16'h0000, er:16'h0000};
        tbl[6] = '{l:16'hDEAD, r:16'hBEEF, m:1'b0, el:16'hDEAD, er:16'hBEEF};
        tbl[7] = '{l:16'h0001, r:16'h8000, m:1'b0, el:16'h0001, er:16'h8000};

        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        lrck_rise_check();

        for (int i = 0; i < 8; i++) apply_row(i);

        // Asynchronous reset mid-frame: outputs must clear before any clk edge.
        wait_cnt(9'd300);
        #1 reset = 1'b0;
        #1 check("async reset clear", {27'b0, audio_mclk, audio_sck, audio_lrck, sample_tick, audio_sdin}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        lrck_rise_check();

        apply_row(0);
        apply_row(1);

        wait_cnt(9'd0);
        t0 = tick_seen;
        repeat (2048) @(posedge clk);
        #1 check("ticks in 4 frames", tick_seen - t0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
